// File: rtl/onehot_decoder_seq.sv
// Registered IN_W-to-2**IN_W one-hot decoder with a valid/ready input, a programmable
// hold time per vector, and a self-running scan mode that walks every output in turn.
module onehot_decoder_seq #(
    parameter  int IN_W        = 3,
    parameter  int HOLD_CYCLES = 4,
    localparam int OUT_W       = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic             scan,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             last
);

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t          state, state_next;
    logic [7:0]      cnt, cnt_next;
    logic [IN_W-1:0] ptr, ptr_next;
    logic [OUT_W-1:0] out_next;
    logic            accept;

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign out_valid = (state != IDLE);
    assign last      = out_valid && (cnt == 8'd0);

    always_comb begin
        in_ready   = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        out_next   = out;

        // A handshake is only taken when no vector is still mid-hold and scan is not requested.
        in_ready = !scan && ((state == IDLE) || ((state == HOLD) && (cnt == 8'd0)));
        accept   = in_valid && in_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HOLD;
                    out_next   = onehot(in);
                    cnt_next   = HOLD_LOAD;
                end else if (scan) begin
                    state_next = SCAN;
                    out_next   = onehot(ptr);
                    cnt_next   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else if (accept) begin
                    out_next = onehot(in);
                    cnt_next = HOLD_LOAD;
                end else if (scan) begin
                    state_next = SCAN;
                    out_next   = onehot(ptr);
                    cnt_next   = HOLD_LOAD;
                end else begin
                    state_next = IDLE;
                    out_next   = '0;
                end
            end
            SCAN: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else if (scan) begin
                    ptr_next = IN_W'(ptr + 1'b1);
                    out_next = onehot(IN_W'(ptr + 1'b1));
                    cnt_next = HOLD_LOAD;
                end else begin
                    state_next = IDLE;
                    ptr_next   = '0;
                    out_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                out_next   = '0;
                cnt_next   = 8'd0;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            ptr   <= '0;
            out   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            out   <= out_next;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: expected vectors are queued as stimulus is
// driven and popped one per clock against the DUT outputs.
module tb_onehot_decoder_seq;

    localparam int HOLD = 4;

    typedef struct packed {
        logic [7:0] vec;
        logic       valid;
        logic       lst;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, scan, out_valid, last;
    logic [2:0] in;
    logic [7:0] out;

    logic       in_valid1, in_ready1, scan1, out_valid1, last1;
    logic [2:0] in1;
    logic [7:0] out1;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    onehot_decoder_seq #(.IN_W(3), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .scan(scan), .out(out), .out_valid(out_valid), .last(last)
    );

    onehot_decoder_seq #(.IN_W(3), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in(in1),
        .scan(scan1), .out(out1), .out_valid(out_valid1), .last(last1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic [7:0] v);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        for (int i = 7; i >= 0; i--) if (v[i] && r == 32'hFFFF_FFFF) r = i;
        return r;
    endfunction

    task automatic push_vec(input int idx);
        exp_t e;
        for (int i = 0; i < HOLD; i++) begin
            e.vec   = 8'd1 << idx;
            e.valid = 1'b1;
            e.lst   = (i == HOLD - 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic tick_cmp();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("out", {24'd0, out}, {24'd0, e.vec});
            chk("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
            chk("last", {31'd0, last}, {31'd0, e.lst});
            chk("onehot_inv", {31'd0, out_valid ? $onehot(out) : (out == 8'd0)}, 32'd1);
        end
    endtask

    // Handshake idx on the coming edge and run up to (and showing) its last cycle.
    task automatic send(input int idx);
        in_valid = 1'b1;
        in       = 3'(idx);
        chk("in_ready_send", {31'd0, in_ready}, 32'd1);
        push_vec(idx);
        tick_cmp();
        chk("encode_loop", encode(out), idx);
        in_valid = 1'b0;
        in       = 3'(7 - idx);
        for (int i = 1; i < HOLD; i++) tick_cmp();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in        = 3'd5;
        scan      = 1'b0;
        in_valid1 = 1'b0;
        in1       = 3'd0;
        scan1     = 1'b0;

        // Reset held two cycles with a pending request: nothing may be decoded.
        push_idle(2);
        tick_cmp();
        tick_cmp();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Single decode, then idle.
        send(3);
        push_idle(2);
        tick_cmp();
        tick_cmp();

        // Back-to-back sweep 0..7.
        for (int k = 0; k < 8; k++) send(k);
        push_idle(2);
        tick_cmp();
        tick_cmp();

        // Ignored request mid-hold.
        in_valid = 1'b1;
        in       = 3'd4;
        push_vec(4);
        tick_cmp();
        in_valid = 1'b0;
        tick_cmp();
        in_valid = 1'b1;
        in       = 3'd2;
        chk("in_ready_midhold", {31'd0, in_ready}, 32'd0);
        tick_cmp();
        in_valid = 1'b0;
        in       = 3'd7;
        tick_cmp();
        push_idle(2);
        tick_cmp();
        tick_cmp();

        // Scan for 40 cycles, wrapping after 80.
        scan = 1'b1;
        for (int k = 0; k < 10; k++) push_vec(k % 8);
        for (int i = 0; i < 40; i++) begin
            tick_cmp();
            if (i == 20) chk("in_ready_scan", {31'd0, in_ready}, 32'd0);
        end
        push_vec(2);
        tick_cmp();
        scan = 1'b0;
        tick_cmp();
        tick_cmp();
        tick_cmp();
        push_idle(2);
        tick_cmp();
        tick_cmp();

        // Reset during the 2nd cycle of an in=6 hold.
        in_valid = 1'b1;
        in       = 3'd6;
        push_vec(6);
        void'(sb.pop_back());
        void'(sb.pop_back());
        tick_cmp();
        in_valid = 1'b0;
        tick_cmp();
        rst_n = 1'b0;
        push_idle(1);
        tick_cmp();
        rst_n = 1'b1;
        chk("in_ready_rst2", {31'd0, in_ready}, 32'd1);

        // Reset during scan at ptr=5, then scan restarts from 01.
        scan = 1'b1;
        for (int k = 0; k < 5; k++) push_vec(k);
        push_vec(5);
        for (int i = 0; i < HOLD - 1; i++) void'(sb.pop_back());
        for (int i = 0; i < 5 * HOLD + 1; i++) tick_cmp();
        rst_n = 1'b0;
        push_idle(1);
        tick_cmp();
        rst_n = 1'b1;
        push_vec(0);
        for (int i = 0; i < HOLD; i++) tick_cmp();
        scan = 1'b0;
        push_idle(2);
        tick_cmp();
        tick_cmp();

        // HOLD_CYCLES=1 instance: a new vector every cycle.
        for (int k = 0; k < 8; k++) begin
            in_valid1 = 1'b1;
            in1       = 3'(k);
            chk("h1_in_ready", {31'd0, in_ready1}, 32'd1);
            @(posedge clk);
            #1;
            chk("h1_out", {24'd0, out1}, 32'd1 << k);
            chk("h1_last", {31'd0, last1}, 32'd1);
        end
        in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk("h1_idle_out", {24'd0, out1}, 32'd0);
        chk("h1_idle_valid", {31'd0, out_valid1}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Registered 3-to-8 one-hot decoder with valid/ready input handshake and a programmable hold time. It converts a binary index into the one-hot vector that our 8-to-3 priority encoder consumes, so the two blocks close the loop. It also has a self-running scan mode that steps through all eight outputs. It sits in front of the encoder, or any row/LED driver needing timed one-hot strobes.

Parameters:
IN_W, 3, index width; OUT_W = 2**IN_W.
HOLD_CYCLES, 4, cycles each decoded vector is held on out; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
in_valid  input  1  index request valid.
in_ready  output  1  block can accept an index this cycle.
in  input  IN_W  binary index to decode.
scan  input  1  level; high selects auto-scan mode.
out  output  OUT_W  registered one-hot vector; all-zero when idle.
out_valid  output  1  out holds a live decoded value.
last  output  1  final hold cycle of current vector.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, out=0, out_valid=0, last=0, hold counter=0, scan pointer=0. Reset wins over every other event, including mid-hold and mid-scan; the output is forced to zero on that same edge.
- States:
  - IDLE: out=0. in_ready=1 when scan=0.
  - HOLD: out valid; counter running.
  - SCAN: auto-stepping.
- IDLE -> HOLD: on in_valid && in_ready. Next edge: out = 1 << in, out_valid=1, counter = HOLD_CYCLES-1. Latency is 1 cycle from accept to out.
- HOLD:
  - counter decrements each cycle.
  - last=1 when counter==0.
  - in_ready=1 only when last=1 and scan=0.
  - If a new index is accepted on the last cycle, the next vector follows back-to-back: no zero gap, out_valid stays 1.
  - Otherwise the block goes to IDLE, out=0, out_valid=0.
- IDLE -> SCAN: when scan=1 and no transfer. Next edge: out = 1 << ptr, where ptr starts at 0, out_valid=1, counter loaded.
- SCAN stepping:
  - On counter==0, ptr increments modulo OUT_W. 7 wraps to 0.
  - out updates to the next one-hot on the following edge.
  - last pulses on each step's final cycle.
- SCAN exit:
  - When scan deasserts, the current vector finishes its hold.
  - The block then returns to IDLE with ptr reset to 0.
  - in_ready stays 0 throughout SCAN.
- scan asserted while in HOLD: the current handshake vector completes first, then the block enters SCAN.
- in is sampled only on an accepted transfer. Changes to in while holding do not affect out.
- in_valid while in_ready=0 is ignored, not queued. The sender must hold in_valid until the handshake completes.
- HOLD_CYCLES=1: every active cycle is a last cycle. Back-to-back accepts give a new vector every cycle.
- Invariant: out is always exactly one-hot when out_valid=1 and all-zero when out_valid=0.
- Counter width is 8 bits.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, in=5 -> out=8'h00, out_valid=0, in_ready=1 after release; no transfer occurs during reset.
- Single decode, HOLD_CYCLES=4: in=3 accepted at cycle t -> out=8'b00001000 for cycles t+1..t+4, last=1 at t+4, out=0 at t+5.
- Sweep all indices 0..7 with back-to-back handshakes on each last cycle -> out is 01,02,04,...,80 with no zero gap. The encoder in the loop returns 0..7, and out_valid is continuous.
- Scan mode: scan=1 for 40 cycles at HOLD_CYCLES=4 -> out steps 01->02->...->80->01, 4 cycles each, wrapping after 80. Drop scan mid-vector -> that vector completes, then out=0.
- Reset mid-operation: rst_n=0 during the 2nd cycle of in=6 hold, and again during scan at ptr=5 -> out=0 on that edge. After release, scan restarts at ptr 0 (out=8'h01).
- Ignored request: pulse in_valid for 1 cycle with in=2 while holding, not on the last cycle -> no effect, out unchanged, in=2 never decoded.
